eq_frame_scheduler: RTL and testbench

Frame sequencer in front of the one-tap equalizer. It captures a per-frame symbol count and generates the equalizer's start-of-frame pulse, held long enough to reset its multiplier. It then gates the sample stream into the equalizer as one 64-sample long-preamble symbol followed by N data symbols, each tagged with a per-symbol tlast. Finally it counts the equalized samples returned, drives a frame-level tlast on the output, and reports frame completion and errors.

---
 rtl/eq_sched_pkg.sv | 16 +
 rtl/eq_sched_sym_counter.sv | 51 +++++
 rtl/eq_frame_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_eq_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_sched_pkg.sv
// Shared types and constants for the equalizer frame scheduler.
package eq_sched_pkg;

    localparam int SYM_LEN_DEF = 64;
    localparam int IQ_W        = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_PRE,
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/eq_sched_sym_counter.sv
// Beat-within-symbol and symbol counter with synchronous clear, enable and wrap.
module eq_sched_sym_counter
    import eq_sched_pkg::*;
#(
    parameter int SYM_LEN = SYM_LEN_DEF,
    parameter int CNT_W   = 8,
    parameter int BEAT_W  = $clog2(SYM_LEN)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic [CNT_W-1:0]  sym_o,
    output logic              last_beat_o
);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  sym_q, sym_d;

    assign last_beat_o = (beat_q == BEAT_W'(SYM_LEN - 1));
    assign beat_o      = beat_q;
    assign sym_o       = sym_q;

    always_comb begin
        beat_d = beat_q;
        sym_d  = sym_q;
        if (clr_i) begin
            beat_d = '0;
            sym_d  = '0;
        end else if (en_i) begin
            if (last_beat_o) begin
                beat_d = '0;
                sym_d  = sym_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_q <= '0;
            sym_q  <= '0;
        end else begin
            beat_q <= beat_d;
            sym_q  <= sym_d;
        end
    end

endmodule

// File: rtl/eq_frame_scheduler.sv
// Frame sequencer in front of the one-tap equalizer: SOF pulse, preamble/data gating, output framing.
// Optional drain watchdog is built only when EQ_SCHED_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for first upstream sample, latches symbol count
// SOF   | sof_o held high, input gated
// PRE   | passing the 64-sample long preamble
// DATA  | passing num_syms data symbols
// DRAIN | input gated, waiting for the remaining equalized samples
// DONE  | one-cycle frame completion
module eq_frame_scheduler
    import eq_sched_pkg::*;
#(
    parameter int SYM_LEN        = SYM_LEN_DEF,
    parameter int CNT_W          = 8,
    parameter int SOF_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] cfg_num_syms,
    input  logic [IQ_W-1:0]  i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic             sof_o,
    output logic [IQ_W-1:0]  eq_tdata,
    output logic             eq_tlast,
    output logic             eq_tvalid,
    input  logic             eq_tready,
    input  logic [IQ_W-1:0]  eq_out_tdata,
    input  logic             eq_out_tlast,
    input  logic             eq_out_tvalid,
    output logic             eq_out_tready,
    output logic [IQ_W-1:0]  o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             err_len_o,
    output logic             err_timeout_o
);

    localparam int BEAT_W = $clog2(SYM_LEN);
    localparam int SOF_W  = $clog2(SOF_CYCLES) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SYM_LEN - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  num_syms_q, num_syms_d;
    logic [SOF_W-1:0]  sof_cnt_q, sof_cnt_d;
    logic              sof_o_q, sof_o_d;
    logic              out_done_q, out_done_d;
    logic              err_len_q, err_len_d;

    logic [BEAT_W-1:0] in_beat, out_beat;
    logic [CNT_W-1:0]  in_sym, out_sym;
    logic              in_last_beat, out_last_beat;
    logic              pass, in_fire, out_fire, cnt_clr, out_cnt_en;
    logic              in_final, out_final;
    logic              unused_eq_out_tlast;

    // Output counting starts at PRE because equalized data may emerge before input completes.
    assign pass       = (state_q == ST_PRE) || (state_q == ST_DATA);
    assign out_cnt_en = pass || (state_q == ST_DRAIN);
    assign cnt_clr    = (state_q == ST_SOF);
    assign in_fire    = i_tvalid & i_tready;
    assign out_fire   = eq_out_tvalid & o_tready;

    // Preamble is symbol 0 on the input side, so the final beat sits in symbol num_syms.
    assign in_final  = in_fire & in_last_beat & (in_sym == num_syms_q);
    assign out_final = out_fire & out_cnt_en & out_last_beat & (out_sym == num_syms_q - CNT_W'(1));

    assign i_tready      = eq_tready & pass;
    assign eq_tvalid     = i_tvalid & pass;
    assign eq_tdata      = i_tdata;
    assign eq_tlast      = pass & (in_beat == LAST_BEAT);
    assign o_tdata       = eq_out_tdata;
    assign o_tvalid      = eq_out_tvalid;
    assign eq_out_tready = o_tready;
    assign o_tlast       = eq_out_tvalid & (out_beat == LAST_BEAT) & (out_sym == num_syms_q - CNT_W'(1));
    assign sof_o         = sof_o_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign frame_done_o  = (state_q == ST_DONE);
    assign err_len_o     = err_len_q;
    assign unused_eq_out_tlast = eq_out_tlast;

    eq_sched_sym_counter #(.SYM_LEN(SYM_LEN), .CNT_W(CNT_W)) u_in_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (cnt_clr),
        .en_i        (in_fire),
        .beat_o      (in_beat),
        .sym_o       (in_sym),
        .last_beat_o (in_last_beat)
    );

    eq_sched_sym_counter #(.SYM_LEN(SYM_LEN), .CNT_W(CNT_W)) u_out_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (cnt_clr),
        .en_i        (out_fire & out_cnt_en),
        .beat_o      (out_beat),
        .sym_o       (out_sym),
        .last_beat_o (out_last_beat)
    );

`ifdef EQ_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_to_q, err_to_d;

    assign err_timeout_o = err_to_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wd_q     <= WD_RELOAD;
            err_to_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            err_to_q <= err_to_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign err_timeout_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        num_syms_d = num_syms_q;
        sof_cnt_d  = sof_cnt_q;
        out_done_d = out_done_q | out_final;
        err_len_d  = in_fire & (i_tlast != in_final);
`ifdef EQ_SCHED_TIMEOUT_EN
        err_to_d   = 1'b0;
        wd_d       = (state_q == ST_DRAIN) ? wd_q : WD_RELOAD;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_tvalid) begin
                    num_syms_d = cfg_num_syms;
                    sof_cnt_d  = SOF_W'(SOF_CYCLES - 1);
                    state_d    = ST_SOF;
                end
            end
            ST_SOF: begin
                out_done_d = 1'b0;
                if (sof_cnt_q == '0) begin
                    state_d = ST_PRE;
                end else begin
                    sof_cnt_d = sof_cnt_q - SOF_W'(1);
                end
            end
            ST_PRE: begin
                if (in_fire && in_last_beat) begin
                    state_d = (num_syms_q == '0) ? ST_DONE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (in_final) begin
                    state_d = (out_done_q || out_final) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_final) begin
                    state_d = ST_DONE;
                end
`ifdef EQ_SCHED_TIMEOUT_EN
                else if (out_fire) begin
                    wd_d = WD_RELOAD;
                end else if (wd_q == '0) begin
                    state_d  = ST_IDLE;
                    err_to_d = 1'b1;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
`endif
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        sof_o_d = (state_d == ST_SOF);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            num_syms_q <= '0;
            sof_cnt_q  <= '0;
            sof_o_q    <= 1'b0;
            out_done_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_syms_q <= num_syms_d;
            sof_cnt_q  <= sof_cnt_d;
            sof_o_q    <= sof_o_d;
            out_done_q <= out_done_d;
            err_len_q  <= err_len_d;
        end
    end

endmodule

// File: tb/tb_eq_frame_scheduler.sv
// Self-checking bench for eq_frame_scheduler: reset/passthrough table, frame sequences, randomized frames.
module tb_eq_frame_scheduler;

    localparam int SYM  = 64;
    localparam int SOFC = 2;
    localparam int TOC  = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  cfg_num_syms;
    logic [31:0] i_tdata, eq_tdata, eq_out_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready, sof_o;
    logic        eq_tlast, eq_tvalid, eq_tready;
    logic        eq_out_tlast, eq_out_tvalid, eq_out_tready;
    logic        o_tlast, o_tvalid, o_tready;
    logic        busy_o, frame_done_o, err_len_o, err_timeout_o;

    always #5 clk_i = ~clk_i;

    eq_frame_scheduler #(
        .SYM_LEN(SYM), .CNT_W(8), .SOF_CYCLES(SOFC), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_num_syms(cfg_num_syms),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .sof_o(sof_o),
        .eq_tdata(eq_tdata), .eq_tlast(eq_tlast), .eq_tvalid(eq_tvalid), .eq_tready(eq_tready),
        .eq_out_tdata(eq_out_tdata), .eq_out_tlast(eq_out_tlast), .eq_out_tvalid(eq_out_tvalid),
        .eq_out_tready(eq_out_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_len_o(err_len_o),
        .err_timeout_o(err_timeout_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // upstream source queue {tlast, data} and equalizer latency queue
    logic [32:0] src_q[$];
    logic [31:0] eqq[$];
    bit bp = 0, stall = 0, sof_prev = 0;
    int cyc = 0, in_k = 0, out_j = 0, exp_n = 0;
    int sof_hi = 0, eqlast_cnt = 0, olast_cnt = 0, done_cnt = 0, errl_cnt = 0, to_cnt = 0;
    int last_done_cyc = -100, sof_gap = -1, last_sof_cyc = 0, first_in_cyc = -1;
    int last_io_cyc = 0, to_cyc = 0;

    task automatic step();
        @(negedge clk_i);
        i_tvalid = (src_q.size() > 0) && (!bp || $urandom_range(0, 3) != 0);
        {i_tlast, i_tdata} = (src_q.size() > 0) ? src_q[0] : 33'd0;
        eq_tready = !bp || ($urandom_range(0, 2) != 0);
        o_tready = !bp || ($urandom_range(0, 1) != 0);
        eq_out_tvalid = (eqq.size() > 0) && !stall && (!bp || $urandom_range(0, 2) != 0);
        eq_out_tdata = (eqq.size() > 0) ? eqq[0] : 32'd0;
        eq_out_tlast = 1'b0;
        #1;
        cyc++;
        if (sof_o) begin
            sof_hi++;
            last_sof_cyc = cyc;
            if (!sof_prev) sof_gap = cyc - last_done_cyc;
        end
        sof_prev = sof_o;
        if ((i_tvalid && i_tready) || (eq_tvalid && eq_tready))
            check("fire_match", longint'(eq_tvalid && eq_tready), longint'(i_tvalid && i_tready));
        if (eq_tvalid && eq_tready && src_q.size() > 0) begin
            check("eq_tlast", eq_tlast, longint'((in_k % SYM) == SYM - 1));
            check("eq_tdata", eq_tdata, src_q[0][31:0]);
            if (in_k >= SYM) eqq.push_back(eq_tdata ^ 32'hA5A5_0F0F);
            if (in_k == 0) first_in_cyc = cyc;
            if (eq_tlast) eqlast_cnt++;
            in_k++;
            last_io_cyc = cyc;
        end
        if (i_tvalid && i_tready && src_q.size() > 0) void'(src_q.pop_front());
        if (eq_out_tvalid && o_tready) begin
            check("o_tlast", o_tlast, longint'(out_j == exp_n * SYM - 1));
            check("o_tdata", o_tdata, eqq[0]);
            if (o_tlast) olast_cnt++;
            void'(eqq.pop_front());
            out_j++;
            last_io_cyc = cyc;
        end
        if (frame_done_o) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (err_len_o) errl_cnt++;
        if (err_timeout_o) begin
            to_cnt++;
            to_cyc = cyc;
        end
    endtask

    // Queue one frame; the expected length-error count follows from the tlast rule alone.
    task automatic load_frame(input int n, input int err_pos, input bit drop_last, output int exp_err);
        int total;
        total = (n + 1) * SYM;
        exp_err = 0;
        cfg_num_syms = 8'(n);
        for (int k = 0; k < total; k++) begin
            bit fin, tl;
            fin = (k == total - 1);
            tl = (fin && !drop_last) || (k == err_pos);
            if (tl != fin) exp_err++;
            src_q.push_back({tl, 32'($urandom())});
        end
        exp_n = n; in_k = 0; out_j = 0; sof_hi = 0; eqlast_cnt = 0; olast_cnt = 0;
        done_cnt = 0; errl_cnt = 0; to_cnt = 0; sof_gap = -1; first_in_cyc = -1;
    endtask

    task automatic run_frame(input string tag, input int n, input int err_pos, input bit drop_last,
                             input int tail);
        int exp_err, guard;
        load_frame(n, err_pos, drop_last, exp_err);
        guard = 0;
        while (done_cnt == 0 && guard < 6000) begin
            step();
            guard++;
        end
        repeat (tail) step();
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_in_beats"}, in_k, (n + 1) * SYM);
        check({tag, "_eq_tlast_cnt"}, eqlast_cnt, n + 1);
        check({tag, "_out_beats"}, out_j, n * SYM);
        check({tag, "_o_tlast_cnt"}, olast_cnt, (n > 0) ? 1 : 0);
        check({tag, "_sof_cycles"}, sof_hi, SOFC);
        check({tag, "_err_len_cnt"}, errl_cnt, exp_err);
        check({tag, "_done_latency"}, last_done_cyc - last_io_cyc, 1);
        if (!bp) check({tag, "_first_beat_after_sof"}, first_in_cyc - last_sof_cyc, 1);
    endtask

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic        eov;
        logic        ordy;
        logic [31:0] eodat;
        logic        busy;
        logic        sof;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int e, guard;
        rst_ni = 1'b0; cfg_num_syms = 8'd2; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b1;
        eq_tready = 1'b1; eq_out_tdata = '0; eq_out_tlast = 1'b0; eq_out_tvalid = 1'b0; o_tready = 1'b1;

        // reset holds IDLE; one frame start is then cut short by a synchronous reset
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_0001, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h2222_0002, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h3333_0003, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h4444_0004, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h5555_0005, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h6666_0006, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h7777_0007, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h8888_0008, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h9999_0009, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA_000A, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            rst_ni = tbl[i].rst_n; i_tvalid = tbl[i].iv; eq_out_tvalid = tbl[i].eov;
            o_tready = tbl[i].ordy; eq_out_tdata = tbl[i].eodat;
            #1;
            check("tbl_busy", busy_o, tbl[i].busy);
            check("tbl_sof", sof_o, tbl[i].sof);
            check("tbl_i_tready", i_tready, 0);
            check("tbl_eq_tvalid", eq_tvalid, 0);
            check("tbl_o_tvalid", o_tvalid, tbl[i].eov);
            check("tbl_o_tdata", o_tdata, tbl[i].eodat);
            check("tbl_eq_out_tready", eq_out_tready, tbl[i].ordy);
            check("tbl_frame_done", frame_done_o, 0);
            check("tbl_err_len", err_len_o, 0);
            check("tbl_err_timeout", err_timeout_o, 0);
        end

        bp = 0;
        run_frame("nominal", 2, -1, 1'b0, 3);
        bp = 1;
        run_frame("backpressure", 2, -1, 1'b0, 3);
        bp = 0;
        run_frame("len_err", 3, SYM + 100, 1'b0, 3);
        run_frame("zero_syms", 0, -1, 1'b0, 0);
        run_frame("b2b", 1, -1, 1'b0, 3);
        check("b2b_sof_low_gap", longint'(sof_gap >= 2), 1);

        for (int r = 0; r < 6; r++) begin
            int n, ep;
            bit dl;
            n = $urandom_range(0, 4);
            dl = ($urandom_range(0, 3) == 0);
            ep = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (n + 1) * SYM - 2) : -1;
            bp = 1;
            run_frame("rand", n, ep, dl, 3);
        end

        // mid-frame reset around data beat 50
        bp = 0;
        load_frame(3, -1, 1'b0, e);
        guard = 0;
        while (in_k < SYM + 50 && guard < 2000) begin
            step();
            guard++;
        end
        check("mrst_reached_beat", in_k, SYM + 50);
        rst_ni = 1'b0;
        step();
        src_q.delete();
        eqq.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step();
        check("mrst_busy", busy_o, 0);
        check("mrst_i_tready", i_tready, 0);
        check("mrst_sof", sof_o, 0);
        check("mrst_frame_done", frame_done_o, 0);
        step();
        check("mrst_stays_idle", busy_o, 0);
        run_frame("after_rst", 1, -1, 1'b0, 3);

        // output stalls while draining
        load_frame(1, -1, 1'b0, e);
        stall = 1;
        guard = 0;
        while (in_k < 2 * SYM && guard < 2000) begin
            step();
            guard++;
        end
        repeat (30) step();
        check("stall_done_cnt", done_cnt, 0);
`ifdef EQ_SCHED_TIMEOUT_EN
        check("to_pulse_cnt", to_cnt, 1);
        check("to_busy", busy_o, 0);
        check("to_cycle_in_range", longint'((to_cyc - last_io_cyc >= TOC) && (to_cyc - last_io_cyc <= TOC + 2)), 1);
        stall = 0;
        eqq.delete();
`else
        check("drain_busy", busy_o, 1);
        check("drain_to_cnt", to_cnt, 0);
        check("drain_i_tready", i_tready, 0);
        stall = 0;
        guard = 0;
        while (done_cnt == 0 && guard < 500) begin
            step();
            guard++;
        end
        check("drain_done_cnt", done_cnt, 1);
        check("drain_out_beats", out_j, SYM);
        check("drain_o_tlast_cnt", olast_cnt, 1);
`endif
        repeat (3) step();
        check("final_idle", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
